error_counter: RTL
==================

// Module: error_counter
// PURPOSE
// - Upstream feeder of the D/A converter: turns AGC error-count pulses into the
//   9-bit error count presented active-low on _DD0.._DD8.
// - Plus/minus pulses are synchronised, edge-detected and queued in a signed
//   backlog. The backlog drains one count per STEP_DIV clocks into a clamped
//   unsigned counter, so the analog error steps at a bounded slew rate.
// PARAMETERS
// - STEP_DIV   8    clocks between counter steps while backlog != 0 (>=2)
// - BACKLOG_W  6    backlog width, signed two's complement (+31..-32 at default)
// - COUNT_MAX  511  upper clamp of error count (<=511)
// PORTS
// - clk        in   1  system clock
// - rst_n      in   1  asynchronous reset, active-low
// - _ECpP      in   1  plus error pulse, active-low, async to clk
// - _ECmP      in   1  minus error pulse, active-low, async to clk
// - ECE        in   1  error-counter enable, high = counting; low = clear and hold
// - _DD0.._DD8 out  1 each  ~count[0]..~count[8], for the D/A converter
// - busy       out  1  backlog != 0 or a step is pending
// - limit      out  1  one-clock strobe when a step is discarded at a clamp
// - ovf        out  1  sticky: backlog saturated and a pulse was lost; cleared by ECE low
// BEHAVIOUR
// - Reset (async): count=0 (all _DDn=1), backlog=0, divider=0, sync flops=1,
//   busy=0, limit=0, ovf=0, state=DISABLED.
// - Input sync: each pulse goes through 2 flops, then a 3rd flop for edge
//   detect. A falling edge gives one event. Latency pin->event is 3 clocks.
//   A held-low input produces exactly one event.
// - Backlog update each clk: +1 for a plus event, -1 for a minus event.
//   Simultaneous plus and minus events cancel (no change, no ovf).
//   If the update would exceed +2^(BACKLOG_W-1)-1 or go below -2^(BACKLOG_W-1),
//   the backlog holds at its limit and ovf sets.
//   A new event and a drain in the same clock both apply (net arithmetic).
// - FSM states:
//   - DISABLED: count, backlog and divider forced 0; events ignored; ovf cleared.
//     Leaves for IDLE on the first clock with ECE=1.
//   - IDLE: divider=0. Goes to PACE when backlog != 0.
//   - PACE: divider increments each clk. At divider==STEP_DIV-1 it applies one
//     step toward zero backlog, then divider returns to 0.
//     - If the backlog is still != 0 after the step, stay in PACE; otherwise go to IDLE.
//     - First step lands STEP_DIV clocks after entering PACE.
//   - From any state, ECE=0 moves to DISABLED on the next clk.
// - Step rules:
//   - backlog>0: count+1 and backlog-1, unless count==COUNT_MAX.
//   - backlog<0: count-1 and backlog+1, unless count==0.
//   - At a clamp the backlog unit is still consumed, count is unchanged and
//     limit pulses for 1 clk.
// - busy = (state==PACE) | (backlog!=0), registered from next-state values.
// - Outputs are registered and change only on clk edges (except at reset).
//   _DDn never glitch between steps.
// - ECE dropping mid-PACE: the step in flight is abandoned and count goes to 0 on
//   the next clk. A pulse edge arriving in that same clk is discarded.
// - Reset mid-operation returns everything to reset values at once.
//   After release, pulse inputs already held low do not produce events.
// TESTING
// - Reset then ECE=1, 5 plus pulses 20 clks apart: count=5 and _DD0.._DD8 =
//   {0,1,0,1,1,1,1,1,1} (_DD0 first). busy drops after the last step.
// - Burst of 10 plus pulses back-to-back, 2 clks apart: steps land exactly 8
//   clks apart; count reaches 10; no step ever lands closer than 8 clks.
// - count=3, then 6 minus pulses: count stops at 0, limit strobes 3 times,
//   backlog ends at 0, busy=0.
// - 40 plus pulses faster than the drain rate (STEP_DIV=8, BACKLOG_W=6): ovf=1,
//   backlog capped at +31; ECE=0 for 1 clk clears count, backlog and ovf.
// - Plus and minus pulses with coincident falling edges: count and backlog are
//   unchanged; one held-low plus pulse lasting 50 clks gives exactly +1.
// - Reset asserted mid-PACE with count=100: all _DDn=1 at once; after release
//   and ECE=1 the block is idle with count=0.

Source files
------------

// File: rtl/error_counter.sv
// error_counter: turns AGC plus/minus error pulses into a slew-limited 9-bit
// error count for the D/A converter. Pulses are synchronised and edge-detected,
// then queued in a signed backlog. The backlog drains one count every STEP_DIV
// clocks into a clamped unsigned counter, presented active-low on _DD0.._DD8.
module error_counter #(
  parameter int STEP_DIV  = 8,    // clocks between counter steps (>= 2)
  parameter int BACKLOG_W = 6,    // signed backlog width
  parameter int COUNT_MAX = 511   // upper clamp of the error count (<= 511)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic _ECpP,
  input  logic _ECmP,
  input  logic ECE,
  output logic _DD0,
  output logic _DD1,
  output logic _DD2,
  output logic _DD3,
  output logic _DD4,
  output logic _DD5,
  output logic _DD6,
  output logic _DD7,
  output logic _DD8,
  output logic busy,
  output logic limit,
  output logic ovf
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_IDLE     = 2'd1,
    S_PACE     = 2'd2
  } state_t;

  localparam int DIV_W    = $clog2(STEP_DIV);
  localparam int SUM_W    = BACKLOG_W + 2;
  localparam int BL_MAX_I = (1 << (BACKLOG_W - 1)) - 1;
  localparam int BL_MIN_I = -(1 << (BACKLOG_W - 1));

  localparam logic [DIV_W-1:0]            DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [8:0]                  CNT_MAX  = 9'(COUNT_MAX);
  localparam logic signed [SUM_W-1:0]     SUM_MAX  = SUM_W'(BL_MAX_I);
  localparam logic signed [SUM_W-1:0]     SUM_MIN  = SUM_W'(BL_MIN_I);
  localparam logic signed [BACKLOG_W-1:0] BL_MAX   = BACKLOG_W'(BL_MAX_I);
  localparam logic signed [BACKLOG_W-1:0] BL_MIN   = BACKLOG_W'(BL_MIN_I);

  // Synchroniser chains: bit 0 is the first flop, bit 2 the edge-detect flop.
  logic [2:0] r_p_sync;
  logic [2:0] r_m_sync;
  // Marks which chain stages hold a real sample taken since reset release, so
  // an input already held low at release cannot look like a falling edge.
  logic [2:0] r_sync_vld;

  state_t                      r_state;
  logic [DIV_W-1:0]            r_div;
  logic signed [BACKLOG_W-1:0] r_backlog;
  logic [8:0]                  r_count;
  logic                        r_busy;
  logic                        r_limit;
  logic                        r_ovf;

  logic                        w_p_evt;
  logic                        w_m_evt;
  logic                        w_bl_pos;
  logic                        w_bl_neg;
  logic                        w_step_now;
  logic signed [SUM_W-1:0]     w_sum;
  logic signed [BACKLOG_W-1:0] w_bl_next;
  logic                        w_ovf_hit;
  logic [8:0]                  w_count_next;
  logic                        w_limit_hit;
  logic                        w_stay_pace;
  logic                        w_busy_next;

  // Two-flop synchronisers plus an edge-detect flop for each pulse input.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_sync   <= '1;
      r_m_sync   <= '1;
      r_sync_vld <= '0;
    end else begin
      r_p_sync   <= {r_p_sync[1:0], _ECpP};
      r_m_sync   <= {r_m_sync[1:0], _ECmP};
      r_sync_vld <= {r_sync_vld[1:0], 1'b1};
    end
  end

  // Event detection, net backlog arithmetic with saturation, and the step.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    w_p_evt      = r_sync_vld[2] & r_p_sync[2] & ~r_p_sync[1];
    w_m_evt      = r_sync_vld[2] & r_m_sync[2] & ~r_m_sync[1];
    w_bl_neg     = r_backlog[BACKLOG_W-1];
    w_bl_pos     = !w_bl_neg && (r_backlog != '0);
    w_step_now   = (r_state == S_PACE) && (r_div == DIV_LAST);

    w_sum        = SUM_W'(r_backlog);
    w_bl_next    = r_backlog;
    w_ovf_hit    = 1'b0;
    w_count_next = r_count;
    w_limit_hit  = 1'b0;
    w_stay_pace  = 1'b0;

    // Coincident plus and minus events cancel; a step drains toward zero.
    if (w_p_evt && !w_m_evt)   w_sum = w_sum + SUM_W'(1);
    if (w_m_evt && !w_p_evt)   w_sum = w_sum - SUM_W'(1);
    if (w_step_now && w_bl_pos) w_sum = w_sum - SUM_W'(1);
    if (w_step_now && w_bl_neg) w_sum = w_sum + SUM_W'(1);

    if (w_sum > SUM_MAX) begin
      w_bl_next = BL_MAX;
      w_ovf_hit = 1'b1;
    end else if (w_sum < SUM_MIN) begin
      w_bl_next = BL_MIN;
      w_ovf_hit = 1'b1;
    end else begin
      w_bl_next = w_sum[BACKLOG_W-1:0];
    end

    // At a clamp the backlog unit is still consumed but the count holds.
    if (w_step_now) begin
      if (w_bl_pos) begin
        if (r_count == CNT_MAX) w_limit_hit  = 1'b1;
        else                    w_count_next = r_count + 9'd1;
      end else if (w_bl_neg) begin
        if (r_count == 9'd0)    w_limit_hit  = 1'b1;
        else                    w_count_next = r_count - 9'd1;
      end
    end

    case (r_state)
      S_IDLE:  w_stay_pace = (r_backlog != '0);
      S_PACE:  w_stay_pace = w_step_now ? (w_bl_next != '0) : 1'b1;
      default: w_stay_pace = 1'b0;
    endcase

    w_busy_next = w_stay_pace | (w_bl_next != '0);
  end

  // Control FSM with the pacing divider, backlog, count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_DISABLED;
      r_div     <= '0;
      r_backlog <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_limit   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (!ECE) begin
      // Disable wins from any state: a step or event in flight is dropped.
      r_state   <= S_DISABLED;
      r_div     <= '0;
      r_backlog <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_limit   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (r_state == S_DISABLED) begin
      // Events arriving on the enabling clock are ignored; everything is zero.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_limit <= 1'b0;
    end else begin
      r_state   <= w_stay_pace ? S_PACE : S_IDLE;
      r_div     <= (r_state == S_PACE && !w_step_now) ? r_div + DIV_W'(1) : '0;
      r_backlog <= w_bl_next;
      r_count   <= w_count_next;
      r_limit   <= w_limit_hit;
      r_ovf     <= r_ovf | w_ovf_hit;
      r_busy    <= w_busy_next;
    end
  end

  assign _DD0  = ~r_count[0];
  assign _DD1  = ~r_count[1];
  assign _DD2  = ~r_count[2];
  assign _DD3  = ~r_count[3];
  assign _DD4  = ~r_count[4];
  assign _DD5  = ~r_count[5];
  assign _DD6  = ~r_count[6];
  assign _DD7  = ~r_count[7];
  assign _DD8  = ~r_count[8];
  assign busy  = r_busy;
  assign limit = r_limit;
  assign ovf   = r_ovf;

endmodule
